// File: rtl/fp_mult_pkg.sv
// Shared definitions for the FP multiplier issue/collect stage.
//   ctrl_state_e : issue/collect FSM states
//   FLAG_*       : bit positions inside res_flags_o
//   op_rec_t     : operand record buffered in the operand FIFO; the tag field
//                  is sized for the widest supported tag (TAG_W <= OP_TAG_MAX_W)
//                  and narrower tags occupy its low bits.
package fp_mult_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_SETTLE,
      ST_HOLD
   } ctrl_state_e;

   localparam int unsigned FLAG_NAN     = 0;
   localparam int unsigned FLAG_INF     = 1;
   localparam int unsigned FLAG_OVF     = 2;
   localparam int unsigned FLAG_UNF     = 3;
   localparam int unsigned FLAG_TIMEOUT = 4;
   localparam int unsigned FLAG_W       = 5;

   localparam int unsigned OP_TAG_MAX_W = 16;

   typedef struct packed {
      logic [31:0]             a;
      logic [31:0]             b;
      logic [OP_TAG_MAX_W-1:0] tag;
   } op_rec_t;

endpackage

// File: rtl/fp_mult_issue_ctrl_if.sv
// Signal bundle between the issue/collect stage and its environment.
//   op_*  : operand stream into the stage (valid/ready)
//   mul_* : start/operands out to the multiplier, done/flags/product back
//   res_* : result stream out of the stage (valid/ready), plus error count
// Suffixes _i/_o are from the stage's point of view.
//   slave  : the issue/collect stage
//   master : the environment (operand source, multiplier, result sink)
interface fp_mult_issue_ctrl_if #(
   parameter int unsigned TAG_W = 4
) ();
   import fp_mult_pkg::*;

   logic              op_valid_i;
   logic              op_ready_o;
   logic [31:0]       op_a_i;
   logic [31:0]       op_b_i;
   logic [TAG_W-1:0]  op_tag_i;

   logic              mul_start_o;
   logic [31:0]       mul_a_o;
   logic [31:0]       mul_b_o;
   logic              mul_done_i;
   logic              mul_nan_i;
   logic              mul_inf_i;
   logic              mul_ovf_i;
   logic              mul_unf_i;
   logic [31:0]       mul_product_i;

   logic              res_valid_o;
   logic              res_ready_i;
   logic [31:0]       res_product_o;
   logic [FLAG_W-1:0] res_flags_o;
   logic [TAG_W-1:0]  res_tag_o;
   logic [7:0]        err_count_o;

   modport slave (
      input  op_valid_i, op_a_i, op_b_i, op_tag_i,
      output op_ready_o,
      output mul_start_o, mul_a_o, mul_b_o,
      input  mul_done_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i, mul_product_i,
      output res_valid_o, res_product_o, res_flags_o, res_tag_o, err_count_o,
      input  res_ready_i
   );

   modport master (
      output op_valid_i, op_a_i, op_b_i, op_tag_i,
      input  op_ready_o,
      input  mul_start_o, mul_a_o, mul_b_o,
      output mul_done_i, mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i, mul_product_i,
      input  res_valid_o, res_product_o, res_flags_o, res_tag_o, err_count_o,
      output res_ready_i
   );

endinterface

// File: rtl/fp_op_fifo.sv
// Circular synchronous FIFO with count-based full/empty.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   push_i     : write data_i (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   data_o     : current head entry
//   full_o     : count == DEPTH
//   empty_o    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module fp_op_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/fp_mult_issue_ctrl.sv
// Operand-issue / result-collection stage around a single-precision multiplier.
//   clk, rst_n : clock, async active-low reset
//   bus        : op stream in, multiplier start/operands out and done/flags/
//                product in, result stream out with tag and error count.
// Operands queue in fp_op_fifo; one multiplication is in flight at a time.
// The product and flags are sampled SETTLE_CYCLES after done, or a timeout
// result (product 0, timeout flag) is forced after TIMEOUT_CYCLES without done.
module fp_mult_issue_ctrl #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TAG_W          = 4,
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fp_mult_issue_ctrl_if.slave  bus
);
   import fp_mult_pkg::*;

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned ST_W = $clog2(SETTLE_CYCLES + 1);

   ctrl_state_e       state_q, state_d;
   op_rec_t           push_rec, head_rec;
   op_rec_t           op_q, op_d;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
   logic [31:0]       res_product_q, res_product_d;
   logic [FLAG_W-1:0] res_flags_q, res_flags_d;
   logic [TAG_W-1:0]  res_tag_q, res_tag_d;
   logic [7:0]        err_q, err_d;
   logic              unused_tag_bits;

   always_comb begin
      push_rec              = '0;
      push_rec.a            = bus.op_a_i;
      push_rec.b            = bus.op_b_i;
      push_rec.tag[TAG_W-1:0] = bus.op_tag_i;
   end

   // op_ready depends on count only, so a full FIFO refuses a push even in a
   // cycle where the FSM pops.
   assign fifo_push = bus.op_valid_i && !fifo_full;
   assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

   fp_op_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(op_rec_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .data_i  (push_rec),
      .pop_i   (fifo_pop),
      .data_o  (head_rec),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Only the low TAG_W bits of the latched tag reach the result.
   assign unused_tag_bits = ^op_q.tag;

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      to_cnt_d      = to_cnt_q;
      st_cnt_d      = st_cnt_q;
      res_product_d = res_product_q;
      res_flags_d   = res_flags_q;
      res_tag_d     = res_tag_q;
      err_d         = err_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               op_d    = head_rec;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            to_cnt_d = '0;
            state_d  = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (bus.mul_done_i) begin
               st_cnt_d = '0;
               state_d  = ST_SETTLE;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               res_product_d              = '0;
               res_flags_d                = '0;
               res_flags_d[FLAG_TIMEOUT]  = 1'b1;
               res_tag_d                  = op_q.tag[TAG_W-1:0];
               state_d                    = ST_HOLD;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_SETTLE: begin
            if (st_cnt_q == ST_W'(SETTLE_CYCLES - 1)) begin
               res_product_d          = bus.mul_product_i;
               res_flags_d            = '0;
               res_flags_d[FLAG_NAN]  = bus.mul_nan_i;
               res_flags_d[FLAG_INF]  = bus.mul_inf_i;
               res_flags_d[FLAG_OVF]  = bus.mul_ovf_i;
               res_flags_d[FLAG_UNF]  = bus.mul_unf_i;
               res_tag_d              = op_q.tag[TAG_W-1:0];
               state_d                = ST_HOLD;
            end else begin
               st_cnt_d = st_cnt_q + ST_W'(1);
            end
         end
         ST_HOLD: begin
            if (bus.res_ready_i) begin
               if ((res_flags_q != '0) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         to_cnt_q      <= '0;
         st_cnt_q      <= '0;
         res_product_q <= '0;
         res_flags_q   <= '0;
         res_tag_q     <= '0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         to_cnt_q      <= to_cnt_d;
         st_cnt_q      <= st_cnt_d;
         res_product_q <= res_product_d;
         res_flags_q   <= res_flags_d;
         res_tag_q     <= res_tag_d;
         err_q         <= err_d;
      end
   end

   assign bus.op_ready_o    = !fifo_full;
   assign bus.mul_start_o   = (state_q == ST_ISSUE);
   assign bus.mul_a_o       = op_q.a;
   assign bus.mul_b_o       = op_q.b;
   assign bus.res_valid_o   = (state_q == ST_HOLD);
   assign bus.res_product_o = res_product_q;
   assign bus.res_flags_o   = res_flags_q;
   assign bus.res_tag_o     = res_tag_q;
   assign bus.err_count_o   = err_q;

endmodule

// File: tb/tb_fp_mult_issue_ctrl.sv
`timescale 1ns/1ps
module tb_fp_mult_issue_ctrl;
   import fp_mult_pkg::*;

   localparam int unsigned TAG_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_mult_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

   fp_mult_issue_ctrl #(
      .FIFO_DEPTH     (4),
      .TAG_W          (TAG_W),
      .SETTLE_CYCLES  (2),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   int exp_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- multiplier model ----------------
   int unsigned m_delay = 2;
   bit          m_never = 1'b0;
   bit          m_fixed = 1'b0;
   logic [31:0] m_prod  = '0;
   logic [3:0]  m_flags = '0;   // {unf, ovf, inf, nan}
   logic        model_done = 1'b0;
   logic        spur_done  = 1'b0;
   int          cd = 0;

   assign bus.mul_done_i = model_done | spur_done;

   initial begin
      bus.mul_product_i = '0;
      {bus.mul_unf_i, bus.mul_ovf_i, bus.mul_inf_i, bus.mul_nan_i} = 4'b0000;
      forever begin
         @(negedge clk);
         model_done = 1'b0;
         if (!rst_n) begin
            cd = 0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  model_done = 1'b1;
                  bus.mul_product_i = m_fixed ? m_prod : (bus.mul_a_o ^ bus.mul_b_o);
                  {bus.mul_unf_i, bus.mul_ovf_i, bus.mul_inf_i, bus.mul_nan_i} = m_flags;
               end
            end
            if (bus.mul_start_o && !m_never) cd = int'(m_delay);
         end
      end
   end

   // ---------------- monitor ----------------
   typedef struct {
      logic [31:0] p;
      logic [4:0]  f;
      logic [3:0]  t;
   } res_t;
   res_t got_q[$];
   int   start_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (bus.res_valid_o && bus.res_ready_i)
               got_q.push_back('{bus.res_product_o, bus.res_flags_o, bus.res_tag_o});
            if (bus.mul_start_o) start_cnt++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_valid(input int max_cyc, output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < max_cyc && !ok) begin
         @(negedge clk);
         cyc++;
         if (bus.res_valid_o) ok = 1'b1;
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] prod;
      logic [3:0]  mflags;
      bit          never;
      logic [31:0] exp_prod;
      logic [4:0]  exp_flags;
      int          exp_lat;   // negedges from push to first res_valid
   } vec_t;

   // Single operation into an idle, empty stage; called just after a negedge.
   task automatic run_vec(input vec_t v, input string nm);
      int cyc;
      bit ok;
      int s0;
      m_fixed = 1'b1;
      m_never = v.never;
      m_prod  = v.prod;
      m_flags = v.mflags;
      s0 = start_cnt;
      bus.op_a_i = v.a;
      bus.op_b_i = v.b;
      bus.op_tag_i = v.tag;
      bus.op_valid_i = 1'b1;
      check({nm, "_op_ready"}, 32'(bus.op_ready_o), 32'd1);
      @(negedge clk);
      bus.op_valid_i = 1'b0;
      check({nm, "_start_n1"}, 32'(bus.mul_start_o), 32'd0);
      @(negedge clk);
      check({nm, "_start_n2"}, 32'(bus.mul_start_o), 32'd1);
      @(negedge clk);
      check({nm, "_start_n3"}, 32'(bus.mul_start_o), 32'd0);
      wait_valid(40, cyc, ok);
      check({nm, "_valid_seen"}, 32'(ok), 32'd1);
      check({nm, "_latency"}, 32'(3 + cyc), 32'(v.exp_lat));
      check({nm, "_product"}, bus.res_product_o, v.exp_prod);
      check({nm, "_flags"}, 32'(bus.res_flags_o), 32'(v.exp_flags));
      check({nm, "_tag"}, 32'(bus.res_tag_o), 32'(v.tag));
      bus.res_ready_i = 1'b1;
      @(negedge clk);
      bus.res_ready_i = 1'b0;
      check({nm, "_valid_drop"}, 32'(bus.res_valid_o), 32'd0);
      if (v.exp_flags != 5'b0 && exp_err < 255) exp_err++;
      check({nm, "_err_count"}, 32'(bus.err_count_o), 32'(exp_err));
      check({nm, "_start_pulses"}, 32'(start_cnt - s0), 32'd1);
      m_never = 1'b0;
   endtask

   vec_t vecs[8];
   vec_t sat_v;
   logic [31:0] bp_a[7];
   logic [31:0] bp_b[7];

   initial begin
      int  cyc;
      bit  ok;
      int  s0;
      int  n0;

      vecs[0] = '{32'h40000000, 32'h40400000, 4'h3, 32'h40C00000, 4'b0000, 1'b0, 32'h40C00000, 5'b00000, 7};
      vecs[1] = '{32'h3F800000, 32'h7F800000, 4'h5, 32'h7F800000, 4'b0010, 1'b0, 32'h7F800000, 5'b00010, 7};
      vecs[2] = '{32'h7F000000, 32'h40000000, 4'h6, 32'h7FFFFFFF, 4'b0100, 1'b0, 32'h7FFFFFFF, 5'b00100, 7};
      vecs[3] = '{32'h7FC00000, 32'h3F800000, 4'h7, 32'h7FC00000, 4'b0001, 1'b0, 32'h7FC00000, 5'b00001, 7};
      vecs[4] = '{32'h00800000, 32'h00800000, 4'h8, 32'h00000000, 4'b1000, 1'b0, 32'h00000000, 5'b01000, 7};
      vecs[5] = '{32'hC0A00000, 32'h3F000000, 4'hF, 32'hC0200000, 4'b0000, 1'b0, 32'hC0200000, 5'b00000, 7};
      vecs[6] = '{32'h3F800000, 32'h3F800000, 4'h9, 32'h3F800000, 4'b0000, 1'b1, 32'h00000000, 5'b10000, 18};
      vecs[7] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 4'h2, 32'h7F800000, 4'b0110, 1'b0, 32'h7F800000, 5'b00110, 7};
      sat_v   = '{32'h7F000000, 32'h7F000000, 4'hC, 32'h7FFFFFFF, 4'b0100, 1'b0, 32'h7FFFFFFF, 5'b00100, 7};

      bus.op_valid_i  = 1'b0;
      bus.op_a_i      = '0;
      bus.op_b_i      = '0;
      bus.op_tag_i    = '0;
      bus.res_ready_i = 1'b0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_op_ready", 32'(bus.op_ready_o), 32'd1);
      check("rst_mul_start", 32'(bus.mul_start_o), 32'd0);
      check("rst_mul_a", bus.mul_a_o, 32'd0);
      check("rst_mul_b", bus.mul_b_o, 32'd0);
      check("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
      check("rst_res_product", bus.res_product_o, 32'd0);
      check("rst_res_flags", 32'(bus.res_flags_o), 32'd0);
      check("rst_res_tag", 32'(bus.res_tag_o), 32'd0);
      check("rst_err_count", 32'(bus.err_count_o), 32'd0);

      // ---- table-driven single operations ----
      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // ---- backpressure: 7 offered, 5 accepted, results in order ----
      got_q.delete();
      m_fixed = 1'b0;
      m_flags = 4'b0000;
      bus.res_ready_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bp_a[i] = 32'h40000000 | (32'(i) << 8);
         bp_b[i] = 32'h00000011 * 32'(i + 1);
         bus.op_a_i = bp_a[i];
         bus.op_b_i = bp_b[i];
         bus.op_tag_i = 4'(i);
         bus.op_valid_i = 1'b1;
         check($sformatf("bp_ready_%0d", i), 32'(bus.op_ready_o), (i < 5) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      bus.op_valid_i = 1'b0;
      wait_valid(60, cyc, ok);
      check("bp_first_valid", 32'(ok), 32'd1);
      check("bp_first_product", bus.res_product_o, bp_a[0] ^ bp_b[0]);
      repeat (4) @(negedge clk);
      check("bp_hold_valid", 32'(bus.res_valid_o), 32'd1);
      check("bp_hold_product", bus.res_product_o, bp_a[0] ^ bp_b[0]);
      check("bp_hold_tag", 32'(bus.res_tag_o), 32'd0);
      check("bp_hold_op_ready", 32'(bus.op_ready_o), 32'd0);
      bus.res_ready_i = 1'b1;
      cyc = 0;
      while (got_q.size() < 5 && cyc < 120) begin
         @(negedge clk);
         cyc++;
      end
      bus.res_ready_i = 1'b0;
      check("bp_result_count", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got_q.size()) begin
            check($sformatf("bp_tag_%0d", i), 32'(got_q[i].t), 32'(i));
            check($sformatf("bp_prod_%0d", i), got_q[i].p, bp_a[i] ^ bp_b[i]);
            check($sformatf("bp_flags_%0d", i), 32'(got_q[i].f), 32'd0);
         end
      end
      repeat (20) @(negedge clk);
      check("bp_no_extra", 32'(got_q.size()), 32'd5);
      check("bp_err_count", 32'(bus.err_count_o), 32'(exp_err));

      // ---- spurious done in IDLE ----
      s0 = start_cnt;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      repeat (5) @(negedge clk);
      check("spur_idle_starts", 32'(start_cnt - s0), 32'd0);
      check("spur_idle_valid", 32'(bus.res_valid_o), 32'd0);
      check("spur_idle_product", bus.res_product_o, bp_a[4] ^ bp_b[4]);

      // ---- spurious done in HOLD ----
      m_fixed = 1'b1;
      m_prod  = 32'h3E800000;
      m_flags = 4'b0000;
      bus.op_a_i = 32'h3F000000;
      bus.op_b_i = 32'h3F000000;
      bus.op_tag_i = 4'hA;
      bus.op_valid_i = 1'b1;
      @(negedge clk);
      bus.op_valid_i = 1'b0;
      wait_valid(40, cyc, ok);
      check("spur_hold_valid_seen", 32'(ok), 32'd1);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      check("spur_hold_valid", 32'(bus.res_valid_o), 32'd1);
      check("spur_hold_product", bus.res_product_o, 32'h3E800000);
      check("spur_hold_flags", 32'(bus.res_flags_o), 32'd0);
      check("spur_hold_tag", 32'(bus.res_tag_o), 32'hA);
      bus.res_ready_i = 1'b1;
      @(negedge clk);
      bus.res_ready_i = 1'b0;
      check("spur_hold_drop", 32'(bus.res_valid_o), 32'd0);

      // ---- error counter saturation ----
      for (int i = 0; i < 300; i++) run_vec(sat_v, "sat");
      check("sat_err_255", 32'(bus.err_count_o), 32'd255);

      // ---- reset in WAIT_DONE with three queued operations ----
      m_never = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.op_a_i = 32'hAAAA0000 | 32'(i + 1);
         bus.op_b_i = 32'h55550000 | 32'(i + 1);
         bus.op_tag_i = 4'(i + 1);
         bus.op_valid_i = 1'b1;
         @(negedge clk);
      end
      bus.op_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_in_flight_a", bus.mul_a_o, 32'hAAAA0001);
      check("mid_in_flight_valid", 32'(bus.res_valid_o), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_mul_start", 32'(bus.mul_start_o), 32'd0);
      check("mid_rst_mul_a", bus.mul_a_o, 32'd0);
      check("mid_rst_mul_b", bus.mul_b_o, 32'd0);
      check("mid_rst_res_valid", 32'(bus.res_valid_o), 32'd0);
      check("mid_rst_res_product", bus.res_product_o, 32'd0);
      check("mid_rst_res_flags", 32'(bus.res_flags_o), 32'd0);
      check("mid_rst_res_tag", 32'(bus.res_tag_o), 32'd0);
      check("mid_rst_err_count", 32'(bus.err_count_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_never = 1'b0;
      exp_err = 0;
      s0 = start_cnt;
      n0 = got_q.size();
      repeat (20) @(negedge clk);
      check("post_rst_op_ready", 32'(bus.op_ready_o), 32'd1);
      check("post_rst_no_start", 32'(start_cnt - s0), 32'd0);
      check("post_rst_no_result", 32'(got_q.size() - n0), 32'd0);
      check("post_rst_valid", 32'(bus.res_valid_o), 32'd0);
      run_vec(vecs[0], "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
